// File: rtl/gcd_host_pkg.sv
// gcd_host_pkg
//   Shared types for the GCD host: controller state encoding, the result
//   record carried through the response FIFO, and the default timeout.
package gcd_host_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ZERO  = 2'd1,
      ISSUE = 2'd2,
      WAIT  = 2'd3
   } state_e;

   typedef struct packed {
      logic [7:0] res;
      logic [3:0] tag;
      logic       err;
   } res_rec_t;

   localparam int TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/gcd_res_fifo.sv
// gcd_res_fifo
//   Two-entry in-order buffer of result records.
//   Ports:
//     clk, resetb   clock, synchronous active-low reset
//     push/push_rec write one record (ignored when full)
//     pop           remove head record (ignored when empty)
//     valid         buffer holds at least one record
//     full          buffer holds two records
//     head_rec      oldest record; all-zero while empty
module gcd_res_fifo
   import gcd_host_pkg::*;
(
   input  logic     clk,
   input  logic     resetb,
   input  logic     push,
   input  res_rec_t push_rec,
   input  logic     pop,
   output logic     valid,
   output logic     full,
   output res_rec_t head_rec
);

   res_rec_t   mem_q [2];
   res_rec_t   mem_d [2];
   logic       wr_ptr_q, wr_ptr_d;
   logic       rd_ptr_q, rd_ptr_d;
   logic [1:0] cnt_q, cnt_d;
   logic       do_push, do_pop;

   assign valid = (cnt_q != 2'd0);
   assign full  = (cnt_q == 2'd2);

   // Masking the head keeps the response fields at zero whenever nothing is
   // pending, not just straight after reset.
   assign head_rec = valid ? mem_q[rd_ptr_q] : '0;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      do_push  = push && !full;
      do_pop   = pop && valid;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_rec;
         wr_ptr_d        = ~wr_ptr_q;
      end
      if (do_pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + 2'd1;
         2'b01:   cnt_d = cnt_q - 2'd1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetb) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         cnt_q    <= 2'd0;
      end else begin
         mem_q[0] <= mem_d[0];
         mem_q[1] <= mem_d[1];
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/gcd_host.sv
// gcd_host
//   Front end for an external GCD engine. Accepts one operand request at a
//   time, short-circuits zero operands, otherwise loads the engine and waits
//   for done with a timeout, and queues results in a 2-entry FIFO.
//   Ports:
//     clk, resetb                 clock, synchronous active-low reset
//     req_valid/req_ready         request handshake; req_u, req_v, req_tag
//     gcd_ld, gcd_u, gcd_v        engine load pulse and operands
//     gcd_done, gcd_res           engine done level and result
//     rsp_valid/rsp_ready         response handshake; rsp_res, rsp_tag, rsp_err
//
//   state | meaning
//   IDLE  | waiting for a request, ready while the FIFO has room
//   ZERO  | an operand was zero, result is u|v without using the engine
//   ISSUE | one-cycle load pulse to the engine, timeout counter cleared
//   WAIT  | waiting for engine done or timeout
module gcd_host
   import gcd_host_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic       clk,
   input  logic       resetb,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [7:0] req_u,
   input  logic [7:0] req_v,
   input  logic [3:0] req_tag,
   output logic       gcd_ld,
   output logic [7:0] gcd_u,
   output logic [7:0] gcd_v,
   input  logic       gcd_done,
   input  logic [7:0] gcd_res,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_res,
   output logic [3:0] rsp_tag,
   output logic       rsp_err
);

   localparam logic [7:0] WAIT_TC = 8'(TIMEOUT - 1);

   state_e     state_q, state_d;
   logic [7:0] u_q, u_d;
   logic [7:0] v_q, v_d;
   logic [3:0] tag_q, tag_d;
   logic [7:0] cnt_q, cnt_d;

   logic       push;
   res_rec_t   push_rec;
   res_rec_t   head_rec;
   logic       fifo_full;

   // Only one request is ever in flight, so room in the FIFO at accept time
   // guarantees the eventual push never finds it full.
   assign req_ready = (state_q == IDLE) && !fifo_full;

   assign gcd_u = ((state_q == ISSUE) || (state_q == WAIT)) ? u_q : 8'd0;
   assign gcd_v = ((state_q == ISSUE) || (state_q == WAIT)) ? v_q : 8'd0;

   always_comb begin
      state_d  = state_q;
      u_d      = u_q;
      v_d      = v_q;
      tag_d    = tag_q;
      cnt_d    = cnt_q;
      gcd_ld   = 1'b0;
      push     = 1'b0;
      push_rec = '0;
      case (state_q)
         IDLE: begin
            if (req_valid && req_ready) begin
               u_d     = req_u;
               v_d     = req_v;
               tag_d   = req_tag;
               state_d = ((req_u == 8'd0) || (req_v == 8'd0)) ? ZERO : ISSUE;
            end
         end
         ZERO: begin
            // gcd(0,x) = x and gcd(0,0) = 0, both equal to u|v here.
            push         = 1'b1;
            push_rec.res = u_q | v_q;
            push_rec.tag = tag_q;
            state_d      = IDLE;
         end
         ISSUE: begin
            gcd_ld  = 1'b1;
            cnt_d   = 8'd0;
            state_d = WAIT;
         end
         WAIT: begin
            push_rec.tag = tag_q;
            // done takes priority over a timeout landing in the same cycle
            if (gcd_done) begin
               push         = 1'b1;
               push_rec.res = gcd_res;
               state_d      = IDLE;
            end else if (cnt_q == WAIT_TC) begin
               push         = 1'b1;
               push_rec.err = 1'b1;
               state_d      = IDLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetb) begin
         state_q <= IDLE;
         u_q     <= 8'd0;
         v_q     <= 8'd0;
         tag_q   <= 4'd0;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         u_q     <= u_d;
         v_q     <= v_d;
         tag_q   <= tag_d;
         cnt_q   <= cnt_d;
      end
   end

   gcd_res_fifo u_res_fifo (
      .clk      (clk),
      .resetb   (resetb),
      .push     (push),
      .push_rec (push_rec),
      .pop      (rsp_ready),
      .valid    (rsp_valid),
      .full     (fifo_full),
      .head_rec (head_rec)
   );

   assign rsp_res = head_rec.res;
   assign rsp_tag = head_rec.tag;
   assign rsp_err = head_rec.err;

endmodule

// File: tb/tb_gcd_host.sv
// tb_gcd_host
//   Directed bench for gcd_host with an engine stub of programmable latency,
//   a queue-based model of expected responses and their visibility cycle, and
//   literal checks on the response log.
module tb_gcd_host;

   localparam int TO = 8;

   logic       clk = 1'b0;
   logic       resetb;
   logic       req_valid;
   logic       req_ready;
   logic [7:0] req_u;
   logic [7:0] req_v;
   logic [3:0] req_tag;
   logic       gcd_ld;
   logic [7:0] gcd_u;
   logic [7:0] gcd_v;
   logic       gcd_done = 1'b0;
   logic [7:0] gcd_res = 8'd0;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] rsp_res;
   logic [3:0] rsp_tag;
   logic       rsp_err;

   gcd_host #(.TIMEOUT(TO)) dut (
      .clk       (clk),
      .resetb    (resetb),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_u     (req_u),
      .req_v     (req_v),
      .req_tag   (req_tag),
      .gcd_ld    (gcd_ld),
      .gcd_u     (gcd_u),
      .gcd_v     (gcd_v),
      .gcd_done  (gcd_done),
      .gcd_res   (gcd_res),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_res   (rsp_res),
      .rsp_tag   (rsp_tag),
      .rsp_err   (rsp_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int gcd_f(input int a, input int b);
      int x;
      int y;
      int t;
      x = a;
      y = b;
      while (y != 0) begin
         t = x % y;
         x = y;
         y = t;
      end
      return x;
   endfunction

   // Engine stub: done drops one cycle after the load pulse (so a stale done
   // is still visible during ISSUE) and rises again lat cycles later; lat = 0
   // means the engine never answers. The first WAIT cycle with done=1 is lat+1.
   int lat = 1;
   int eng_lat = 0;
   int rem = 0;
   bit eng_start = 1'b0;
   int eng_u = 0;
   int eng_v = 0;

   always @(negedge clk) begin
      if (eng_start) begin
         gcd_done = 1'b0;
         gcd_res  = 8'hA5;
         rem      = eng_lat;
      end else if (rem > 0) begin
         rem--;
         if (rem == 0) begin
            gcd_done = 1'b1;
            gcd_res  = 8'(gcd_f(eng_u, eng_v));
         end
      end
      eng_start = gcd_ld;
      if (gcd_ld) begin
         eng_u   = int'(gcd_u);
         eng_v   = int'(gcd_v);
         eng_lat = lat;
      end
   end

   // Model: each accepted request becomes an expected record with the cycle
   // from which it is visible at the FIFO head.
   typedef struct {
      int res;
      int tag;
      int err;
      int vis;
   } exp_t;

   typedef struct {
      int res;
      int tag;
      int err;
      int cyc;
   } rsp_t;

   exp_t expq[$];
   rsp_t rsp_log[$];
   int   ld_log[$];
   int   acc_log[$];

   int cyc = 0;
   bit rst_at_edge = 1'b0;
   bit run = 1'b0;
   int ld_cyc = -1;
   int win_lo = -1;
   int win_hi = -2;
   int op_u = 0;
   int op_v = 0;

   always @(posedge clk) begin
      cyc++;
      rst_at_edge = (resetb === 1'b0);
   end

   always @(negedge clk) begin : cmp_proc
      int   n_vis;
      bit   inflight;
      exp_t e;
      rsp_t r;
      if (run) begin
         if (rst_at_edge) begin
            expq.delete();
            ld_cyc = -1;
            win_lo = -1;
            win_hi = -2;
         end
         n_vis    = 0;
         inflight = 1'b0;
         foreach (expq[i]) begin
            if (expq[i].vis <= cyc) n_vis++;
            else inflight = 1'b1;
         end
         check("req_ready", 32'(req_ready), int'(!inflight && (n_vis < 2)));
         check("rsp_valid", 32'(rsp_valid), int'(n_vis > 0));
         check("gcd_ld", 32'(gcd_ld), int'(cyc == ld_cyc));
         if ((cyc >= win_lo) && (cyc <= win_hi)) begin
            check("gcd_u_held", 32'(gcd_u), op_u);
            check("gcd_v_held", 32'(gcd_v), op_v);
         end else if (!inflight) begin
            check("gcd_u_idle", 32'(gcd_u), 0);
            check("gcd_v_idle", 32'(gcd_v), 0);
         end
         if (n_vis > 0) begin
            check("rsp_res", 32'(rsp_res), expq[0].res);
            check("rsp_tag", 32'(rsp_tag), expq[0].tag);
            check("rsp_err", 32'(rsp_err), expq[0].err);
         end
         if (gcd_ld === 1'b1) ld_log.push_back(cyc);
         if ((resetb === 1'b1) && (rsp_ready === 1'b1)) begin
            if (rsp_valid === 1'b1) begin
               r.res = int'(rsp_res);
               r.tag = int'(rsp_tag);
               r.err = int'(rsp_err);
               r.cyc = cyc;
               rsp_log.push_back(r);
            end
            if (n_vis > 0) void'(expq.pop_front());
         end
         if ((resetb === 1'b1) && (req_valid === 1'b1) && (req_ready === 1'b1)) begin
            acc_log.push_back(cyc);
            e.tag = int'(req_tag);
            if ((req_u == 8'd0) || (req_v == 8'd0)) begin
               e.res = int'(req_u | req_v);
               e.err = 0;
               e.vis = cyc + 2;
            end else begin
               ld_cyc = cyc + 1;
               win_lo = cyc + 1;
               op_u   = int'(req_u);
               op_v   = int'(req_v);
               if ((lat >= 1) && (lat <= TO - 1)) begin
                  e.res = gcd_f(int'(req_u), int'(req_v));
                  e.err = 0;
                  e.vis = cyc + 3 + lat;
               end else begin
                  e.res = 0;
                  e.err = 1;
                  e.vis = cyc + TO + 2;
               end
               win_hi = e.vis - 1;
            end
            expq.push_back(e);
         end
      end
   end

   task automatic send(input int u, input int v, input int tag, input int l);
      bit ok;
      @(posedge clk);
      #1;
      lat       = l;
      req_u     = 8'(u);
      req_v     = 8'(v);
      req_tag   = 4'(tag);
      req_valid = 1'b1;
      ok        = 1'b0;
      for (int i = 0; (i < 200) && !ok; i++) begin
         @(negedge clk);
         ok = (req_ready === 1'b1);
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL req_accept: req_ready stayed low for 200 cycles (tag %0d)", tag);
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_log(input int n);
      for (int i = 0; (i < 300) && (rsp_log.size() < n); i++) @(negedge clk);
      if (rsp_log.size() < n) begin
         checks++;
         errors++;
         $display("FAIL rsp_wait: got %0d responses expected %0d", rsp_log.size(), n);
         $display("CHECKS %0d ERRORS %0d", checks, errors);
         $fatal(1, "response wait expired");
      end
   endtask

   task automatic check_log(input string name, input int idx, input int res, input int tag, input int err);
      check({name, "_res"}, 32'(rsp_log[idx].res), res);
      check({name, "_tag"}, 32'(rsp_log[idx].tag), tag);
      check({name, "_err"}, 32'(rsp_log[idx].err), err);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int n_ld;
      int base;
      resetb    = 1'b0;
      req_valid = 1'b0;
      req_u     = 8'd0;
      req_v     = 8'd0;
      req_tag   = 4'd0;
      rsp_ready = 1'b1;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 1);
      check("rst_rsp_valid", 32'(rsp_valid), 0);
      check("rst_gcd_ld", 32'(gcd_ld), 0);
      check("rst_gcd_u", 32'(gcd_u), 0);
      check("rst_gcd_v", 32'(gcd_v), 0);
      check("rst_rsp_res", 32'(rsp_res), 0);
      check("rst_rsp_tag", 32'(rsp_tag), 0);
      check("rst_rsp_err", 32'(rsp_err), 0);
      @(posedge clk);
      #1;
      resetb = 1'b1;
      run    = 1'b1;

      // (48,18) through the engine
      n_ld = ld_log.size();
      send(48, 18, 3, 4);
      wait_log(1);
      check_log("gcd48_18", 0, 6, 3, 0);
      check("gcd48_18_ld_pulses", 32'(ld_log.size() - n_ld), 1);

      // done is still high from the previous op when this one issues
      send(255, 255, 5, 3);
      wait_log(2);
      check_log("stale_done", 1, 255, 5, 0);

      // zero operands, back to back, engine untouched
      n_ld = ld_log.size();
      send(0, 9, 1, 2);
      send(0, 0, 2, 2);
      wait_log(4);
      check_log("zero_0_9", 2, 9, 1, 0);
      check("zero_0_9_latency", 32'(rsp_log[2].cyc - acc_log[2]), 2);
      check_log("zero_0_0", 3, 0, 2, 0);
      check("zero_back_to_back", 32'(acc_log[3] - acc_log[2]), 2);
      check("zero_no_ld", 32'(ld_log.size() - n_ld), 0);

      // engine never answers
      send(9, 6, 7, 0);
      wait_log(5);
      check_log("timeout", 4, 0, 7, 1);
      check("timeout_latency", 32'(rsp_log[4].cyc - ld_log[ld_log.size() - 1]), TO + 1);

      // done in the last WAIT cycle wins; one cycle later times out
      send(21, 14, 8, TO - 1);
      wait_log(6);
      check_log("done_at_limit", 5, 7, 8, 0);
      check("done_at_limit_latency", 32'(rsp_log[5].cyc - ld_log[ld_log.size() - 1]), TO + 1);
      send(21, 14, 9, TO);
      wait_log(7);
      check_log("done_past_limit", 6, 0, 9, 1);

      // back-pressure: FIFO fills, request side stalls until a pop
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      base = rsp_log.size();
      send(12, 8, 10, 2);
      send(7, 3, 11, 2);
      repeat (12) @(negedge clk);
      check("bp_full_req_ready", 32'(req_ready), 0);
      check("bp_full_rsp_valid", 32'(rsp_valid), 1);
      check("bp_head_stable", 32'(rsp_res), 4);
      fork
         send(100, 75, 12, 2);
         begin
            repeat (3) @(posedge clk);
            #1;
            rsp_ready = 1'b1;
         end
      join
      wait_log(base + 3);
      check_log("bp_order0", base, 4, 10, 0);
      check_log("bp_order1", base + 1, 1, 11, 0);
      check_log("bp_order2", base + 2, 25, 12, 0);

      // reset pulse while waiting on the engine
      base = rsp_log.size();
      send(30, 12, 13, 5);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      resetb = 1'b0;
      @(posedge clk);
      #1;
      resetb = 1'b1;
      @(negedge clk);
      check("midrst_rsp_valid", 32'(rsp_valid), 0);
      check("midrst_gcd_ld", 32'(gcd_ld), 0);
      check("midrst_req_ready", 32'(req_ready), 1);
      check("midrst_gcd_u", 32'(gcd_u), 0);
      repeat (15) @(negedge clk);
      check("midrst_no_result", 32'(rsp_log.size() - base), 0);
      send(0, 5, 14, 1);
      wait_log(base + 1);
      check_log("after_rst", base, 5, 14, 0);

      repeat (5) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
